// File: rtl/muller_c_pkg.sv
// Shared state encoding, per-state C-element drive levels and counter width
// for the Muller C-element characterisation sequencer.
package muller_c_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RISE,
        ST_HOLD_H,
        ST_FALL,
        ST_HOLD_L,
        ST_RECOVER,
        ST_DONE
    } state_t;

    // {A,B} levels applied to the element while in each state
    localparam logic [1:0] AB_IDLE    = 2'b00;
    localparam logic [1:0] AB_RISE    = 2'b11;
    localparam logic [1:0] AB_HOLD_H  = 2'b10;
    localparam logic [1:0] AB_FALL    = 2'b00;
    localparam logic [1:0] AB_HOLD_L  = 2'b01;
    localparam logic [1:0] AB_RECOVER = 2'b00;
    localparam logic [1:0] AB_DONE    = 2'b00;

    function automatic logic [1:0] drive_ab(input state_t s);
        logic [1:0] ab;
        case (s)
            ST_IDLE:    ab = AB_IDLE;
            ST_RISE:    ab = AB_RISE;
            ST_HOLD_H:  ab = AB_HOLD_H;
            ST_FALL:    ab = AB_FALL;
            ST_HOLD_L:  ab = AB_HOLD_L;
            ST_RECOVER: ab = AB_RECOVER;
            ST_DONE:    ab = AB_DONE;
            default:    ab = AB_IDLE;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/muller_c_sync2.sv
// Two-flop synchronizer for the asynchronous C-element output; two edges of
// latency, resets both stages to 0.
module muller_c_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/muller_c_sequencer.sv
// Round-robin shares one C-element and runs a rise/hold/fall/hold handshake per grant;
// grant 1 cycle after request, 3+HOLD_CYC+3+HOLD_CYC+1 cycles per ideal transaction.
module muller_c_sequencer
    import muller_c_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TIMEOUT  = 16,
    parameter int HOLD_CYC = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [NREQ-1:0] done_o,
    output logic            err_o,
    output logic            busy_o,
    output logic            c_a_o,
    output logic            c_b_o,
    input  logic            c_y_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [NREQ-1:0]  ONE_HOT0  = NREQ'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             fail;
    logic             fail_nxt;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] pick_idx;
    logic             y_s;

    // First set bit searching upward from from+1 with wrap; lowest offset wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [IDX_W-1:0] from);
        logic [IDX_W-1:0] idx;
        logic [NREQ-1:0]  sh;
        int               cand;
        idx = from;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(from) + k) % NREQ;
            sh   = req >> cand;
            if (sh[0]) idx = cand[IDX_W-1:0];
        end
        return idx;
    endfunction

    muller_c_sync2 u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (c_y_i),
        .q   (y_s)
    );

    assign pick_idx = rr_pick(req_i, last);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail;
        case (state)
            ST_IDLE: begin
                if (|req_i) state_nxt = ST_RISE;
            end
            ST_RISE: begin
                if (y_s) begin
                    state_nxt = ST_HOLD_H;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_RECOVER;
                    fail_nxt  = 1'b1;
                end
            end
            ST_HOLD_H: begin
                if (!y_s) fail_nxt = 1'b1;
                if (cnt == HOLD_LAST) state_nxt = fail_nxt ? ST_RECOVER : ST_FALL;
            end
            ST_FALL: begin
                if (!y_s) begin
                    state_nxt = ST_HOLD_L;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_RECOVER;
                    fail_nxt  = 1'b1;
                end
            end
            ST_HOLD_L: begin
                if (y_s) fail_nxt = 1'b1;
                if (cnt == HOLD_LAST) state_nxt = ST_DONE;
            end
            ST_RECOVER: begin
                // y_s still reflects the old drive for the first two cycles
                if ((!y_s && cnt >= SETTLE) || cnt == TO_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                fail_nxt  = 1'b0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt   <= '0;
            fail  <= 1'b0;
            gnt_o <= '0;
            last  <= IDX_W'(NREQ - 1);
            c_a_o <= 1'b0;
            c_b_o <= 1'b0;
        end else begin
            if (state_nxt != state) cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            fail <= fail_nxt;
            if (state == ST_IDLE && state_nxt == ST_RISE) begin
                gnt_o <= ONE_HOT0 << pick_idx;
                last  <= pick_idx;
            end else if (state == ST_DONE) begin
                gnt_o <= '0;
            end
            {c_a_o, c_b_o} <= drive_ab(state_nxt);
        end
    end

    always_comb begin
        busy_o = (state != ST_IDLE);
        done_o = '0;
        err_o  = 1'b0;
        if (state == ST_DONE) begin
            done_o = gnt_o;
            err_o  = fail;
        end
    end

endmodule

// File: tb/tb_muller_c_sequencer.sv
// Directed bench for muller_c_sequencer: a transaction table plus hand-written
// reset sequence, with a behavioural C-element in ideal, stuck-at-0 and AND modes.
module tb_muller_c_sequencer;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic [3:0] done_o;
    logic       err_o;
    logic       busy_o;
    logic       c_a_o;
    logic       c_b_o;
    logic       c_y_i = 1'b0;

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0 ideal C-element, 1 stuck at 0, 2 y = A & B

    typedef struct {
        logic [3:0] req;
        int         mode;
        logic [3:0] gnt;
        int         off;      // sample index (after grant) where DONE is visible
        logic       err;
        int         drop_at;  // sample index after which req_i is released, -1 keeps it
    } vec_t;

    vec_t vecs[8];

    muller_c_sequencer #(
        .NREQ     (4),
        .TIMEOUT  (16),
        .HOLD_CYC (4)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .busy_o   (busy_o),
        .c_a_o    (c_a_o),
        .c_b_o    (c_b_o),
        .c_y_i    (c_y_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(c_a_o, c_b_o, mode) begin
        case (mode)
            0: if (c_a_o == c_b_o) c_y_i = c_a_o;
            1: c_y_i = 1'b0;
            default: c_y_i = c_a_o & c_b_o;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_ab(input int m, input int k);
        logic [1:0] ab;
        ab = 2'b00;
        case (m)
            0: if (k < 3) ab = 2'b11; else if (k < 7) ab = 2'b10;
               else if (k < 10) ab = 2'b00; else if (k < 14) ab = 2'b01;
            1: if (k < 16) ab = 2'b11;
            default: if (k < 3) ab = 2'b11; else if (k < 7) ab = 2'b10;
        endcase
        return ab;
    endfunction

    function automatic logic [11:0] outs();
        return {gnt_o, done_o, err_o, busy_o, c_a_o, c_b_o};
    endfunction

    task automatic run_vec(input int v, input vec_t t);
        logic [11:0] exp;
        req_i = t.req;
        mode  = t.mode;
        for (int k = 0; k <= t.off; k++) begin
            @(negedge wb_clk_i);
            exp = {t.gnt, (k == t.off) ? t.gnt : 4'b0000,
                   (k == t.off) ? t.err : 1'b0, 1'b1, exp_ab(t.mode, k)};
            check($sformatf("v%0d_k%0d", v, k), 32'(outs()), 32'(exp));
            if (k == t.drop_at) req_i = 4'b0000;
        end
        @(negedge wb_clk_i);
        check($sformatf("v%0d_idle", v), 32'({gnt_o, done_o, busy_o}), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b1111, 0, 4'b0001, 14, 1'b0, -1};
        vecs[1] = '{4'b1111, 0, 4'b0010, 14, 1'b0, -1};
        vecs[2] = '{4'b1111, 0, 4'b0100, 14, 1'b0,  0};
        vecs[3] = '{4'b0100, 0, 4'b0100, 14, 1'b0,  0};
        vecs[4] = '{4'b0011, 1, 4'b0001, 19, 1'b1,  0};
        vecs[5] = '{4'b0011, 2, 4'b0010, 10, 1'b1,  0};
        vecs[6] = '{4'b0010, 0, 4'b0010, 14, 1'b0,  8};
        vecs[7] = '{4'b1000, 0, 4'b1000, 14, 1'b0,  0};

        wb_rst_i = 1'b1;
        req_i    = 4'b0000;
        repeat (3) @(negedge wb_clk_i);
        check("reset_outs", 32'(outs()), 32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("idle_after_reset", 32'(outs()), 32'd0);

        for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

        // reset two cycles into RISE after a grant to requester 2
        mode  = 0;
        req_i = 4'b0100;
        @(negedge wb_clk_i);
        check("rst_pre_gnt", 32'(gnt_o), 32'h4);
        req_i = 4'b0000;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        #1;
        check("rst_async_outs", 32'(outs()), 32'd0);
        repeat (2) begin
            @(negedge wb_clk_i);
            check("rst_held_outs", 32'(outs()), 32'd0);
        end
        wb_rst_i = 1'b0;
        req_i    = 4'b1001;
        @(negedge wb_clk_i);
        check("rst_first_gnt", 32'(gnt_o), 32'h1);
        req_i = 4'b0000;
        repeat (14) @(negedge wb_clk_i);
        check("rst_next_done", 32'({done_o, err_o}), 32'({4'b0001, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muller_c_sequencer.md
# muller_c_sequencer

Synchronous controller that shares one Muller C-element among `NREQ` requesters and runs a complete characterisation handshake on it for each grant. A grant steps the element through rise, hold-high, fall and hold-low phases and checks its output at each phase. Arbitration is round-robin. The block sits between the user-project logic and the `c_element` instance inside `muller_c_proj`. It drives the element's two inputs and samples its asynchronous output through a two-flop synchronizer.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: maximum cycles spent in a wait phase before error, 4..255.
- `HOLD_CYC`, 4: cycles spent in each hold phase, 3..15.
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  NREQ  per-requester level request for one handshake transaction.
- `gnt_o`  out  NREQ  one-hot grant, held for the whole transaction.
- `done_o`  out  NREQ  one-cycle pulse to the granted requester when its transaction ends.
- `err_o`  out  1  one-cycle pulse coincident with `done_o` when the transaction failed.
- `busy_o`  out  1  high whenever state != IDLE.
- `c_a_o`  out  1  C-element input A, registered.
- `c_b_o`  out  1  C-element input B, registered.
- `c_y_i`  in  1  C-element output, asynchronous; `y_s` is its synchronized copy.

## Operation
- FSM states: IDLE, RISE, HOLD_H, FALL, HOLD_L, RECOVER, DONE. Each state drives (A,B) as follows:
  - IDLE: (0,0)
  - RISE: (1,1)
  - HOLD_H: (1,0)
  - FALL: (0,0)
  - HOLD_L: (0,1)
  - RECOVER: (0,0)
  - DONE: (0,0)
- `c_a_o`/`c_b_o` are decoded from next-state and registered, so they change on the same edge as the state.
- IDLE with any `req_i` bit set:
  - Select the first set bit searching upward, with wrap, from `last+1`.
  - Register that bit in `gnt_o`, set `last` to its index, and go to RISE.
- RISE: wait for `y_s==1`, then go to HOLD_H. If `TIMEOUT` cycles pass without it, go to RECOVER and latch `fail`.
- HOLD_H: stay exactly `HOLD_CYC` cycles. If `y_s==0` in any of those cycles, latch `fail`. Then go to FALL if no failure, otherwise RECOVER.
- FALL: wait for `y_s==0`, then go to HOLD_L. On timeout, go to RECOVER and latch `fail`.
- HOLD_L: stay `HOLD_CYC` cycles. If `y_s==1` in any of those cycles, latch `fail`. Then go to DONE.
- RECOVER: drive (0,0) and wait for `y_s==0` or `TIMEOUT` cycles, whichever comes first, then go to DONE. A RECOVER timeout does not generate a second error.
- DONE (one cycle):
  - `done_o = gnt_o`, `err_o = fail`.
  - `gnt_o` and `fail` clear on the exit edge.
  - Next state is IDLE.
- Dropping `req_i` mid-transaction is ignored; the transaction always completes. A requester still asserting `req_i` in IDLE is treated as a new request.
- The phase counter is 8 bits. It clears on every state entry and saturates at 255.

## Timing
- Reset values: state IDLE, `gnt_o=0`, `done_o=0`, `err_o=0`, `busy_o=0`, `c_a_o=c_b_o=0`, synchronizer flops 0, `fail=0`, `last=NREQ-1` so requester 0 wins first.
- `y_s` latency is 2 edges.
- With an ideal zero-delay element, a full transaction from the grant edge to the DONE exit edge takes 3 (RISE) + `HOLD_CYC` + 3 (FALL) + `HOLD_CYC` + 1 (DONE) cycles, which is 15 at the defaults.
- Arbitration: grant is registered 1 cycle after `req_i` is seen in IDLE. The minimum gap between back-to-back transactions is 1 IDLE cycle.
- A hold violation caused within the first `HOLD_CYC-2` cycles of a hold phase is guaranteed to be detected. Later glitches may go unseen; this is accepted.
- Timeout: in a wait state, when the counter reaches `TIMEOUT-1` and the condition is still false, the FSM transitions on that edge.
- Asserting reset mid-transaction returns every output to its reset value immediately. No `done_o` is produced.

## Structure
- Package `muller_c_pkg` holds:
  - the state enum typedef;
  - the (A,B) drive constants per state;
  - a `CNT_W=8` constant.
- Sub-module `muller_c_sync2`: a 2-flop synchronizer with async active-high reset to 0, instantiated once for `c_y_i`.
- The round-robin picker stays inline as a function.

## Test plan
- Bench model: ideal C-element, `y` follows A when A==B and otherwise holds.
- Single request: after reset, pulse `req_i=4'b0100`.
  - `gnt_o=4'b0100` one cycle later.
  - (A,B) sequence 11, 10, 01 (with 00 between phases).
  - `done_o=4'b0100`, `err_o=0` 15 cycles after the grant edge.
- Round robin: hold `req_i=4'b1111` for three transactions. Grants are 0001, 0010, 0100, each separated by one IDLE cycle.
- Stuck-at-0 element (`c_y_i=0`):
  - RISE times out after 16 cycles, then RECOVER exits after 3 cycles.
  - `done_o` pulses together with `err_o=1`.
- Non-holding element (`y=A&B`): `y_s` drops in HOLD_H cycle 3 and HOLD_H latches `fail`; the transaction ends through RECOVER with `err_o=1`.
- Reset mid-RISE: assert `wb_rst_i` 2 cycles into RISE.
  - All outputs 0 immediately and no `done_o`.
  - After release, `req_i=4'b0001` is granted first.
- Request withdrawal: drop `req_i` in FALL. The transaction still completes with `done_o` and `err_o=0`.
